// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle MIPS controller: state codes, opcodes,
// datapath mux selects and the control-strobe bundle.
package multicycle_pkg;

   typedef enum logic [3:0] {
      S_RESET  = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_MEMADR = 4'd3,
      S_MEMRD  = 4'd4,
      S_MEMWB  = 4'd5,
      S_MEMWR  = 4'd6,
      S_REX    = 4'd7,
      S_RWB    = 4'd8,
      S_BEQ    = 4'd9,
      S_JMP    = 4'd10
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [1:0] SRCB_B       = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_SEXT    = 2'b10;
   localparam logic [1:0] SRCB_SEXT_SH = 2'b11;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       pcwrite;
      logic       pcwritecond;
      logic       iord;
      logic       memread;
      logic       memwrite;
      logic       irwrite;
      logic       memtoreg;
      logic       regdst;
      logic       regwrite;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] aluop;
      logic [1:0] pcsource;
      logic       instr_done;
   } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath/memory bundle: opcode and memory handshake in,
// datapath control strobes out.
interface multicycle_control_if;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       pcwrite;
   logic       pcwritecond;
   logic       iord;
   logic       memread;
   logic       memwrite;
   logic       irwrite;
   logic       memtoreg;
   logic       regdst;
   logic       regwrite;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic [1:0] aluop;
   logic [1:0] pcsource;

   modport master (
      input  opcode, mem_ready,
      output pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
             memtoreg, regdst, regwrite, alusrca, alusrcb, aluop, pcsource
   );

   modport slave (
      output opcode, mem_ready,
      input  pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
             memtoreg, regdst, regwrite, alusrca, alusrcb, aluop, pcsource
   );
endinterface

// File: rtl/mc_out_decode.sv
// Moore output decode for the multicycle controller; mem_ready only gates the
// strobes that complete a memory transfer.
module mc_out_decode
   import multicycle_pkg::*;
(
   input  state_t state,
   input  logic   mem_ready,
   output ctrl_t  ctrl
);

   always_comb begin
      // NOTE: every field defaults to 0 first so no path through the case can infer a latch.
      ctrl = '0;
      unique case (state)
         S_FETCH: begin
            ctrl.memread = 1'b1;
            ctrl.alusrcb = SRCB_FOUR;
            ctrl.irwrite = mem_ready;
            ctrl.pcwrite = mem_ready;
         end
         S_DECODE: ctrl.alusrcb = SRCB_SEXT_SH;
         S_MEMADR: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = SRCB_SEXT;
         end
         S_MEMRD: begin
            ctrl.memread = 1'b1;
            ctrl.iord    = 1'b1;
         end
         S_MEMWB: begin
            ctrl.regwrite   = 1'b1;
            ctrl.memtoreg   = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         // The store retires only in the cycle memory accepts it.
         S_MEMWR: begin
            ctrl.memwrite   = 1'b1;
            ctrl.iord       = 1'b1;
            ctrl.instr_done = mem_ready;
         end
         S_REX: begin
            ctrl.alusrca = 1'b1;
            ctrl.aluop   = ALUOP_FUNCT;
         end
         S_RWB: begin
            ctrl.regdst     = 1'b1;
            ctrl.regwrite   = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         S_BEQ: begin
            ctrl.alusrca     = 1'b1;
            ctrl.aluop       = ALUOP_SUB;
            ctrl.pcwritecond = 1'b1;
            ctrl.pcsource    = PCSRC_ALUOUT;
            ctrl.instr_done  = 1'b1;
         end
         S_JMP: begin
            ctrl.pcwrite    = 1'b1;
            ctrl.pcsource   = PCSRC_JUMP;
            ctrl.instr_done = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS sequencer: state register, opcode-driven next-state logic
// and retired-instruction counter.
module multicycle_control
   import multicycle_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic                clk,
   input  logic                reset,
   multicycle_control_if.master bus,
   output logic [3:0]          state,
   output logic                instr_done,
   output logic                illegal_op,
   output logic [CNT_W-1:0]    retired
);

   state_t state_q, state_d;
   ctrl_t  ctrl;

   mc_out_decode u_decode (
      .state     (state_q),
      .mem_ready (bus.mem_ready),
      .ctrl      (ctrl)
   );

   always_comb begin
      state_d    = S_FETCH;
      illegal_op = 1'b0;
      unique case (state_q)
         S_RESET:  state_d = S_FETCH;
         S_FETCH:  state_d = bus.mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            unique case (bus.opcode)
               OP_RTYPE:     state_d = S_REX;
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_BEQ:       state_d = S_BEQ;
               OP_J:         state_d = S_JMP;
               default:      illegal_op = 1'b1;
            endcase
         end
         S_MEMADR: state_d = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  state_d = bus.mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWR:  state_d = bus.mem_ready ? S_FETCH : S_MEMWR;
         S_REX:    state_d = S_RWB;
         // MEMWB, RWB, BEQ, JMP and the unused encodings all return to FETCH.
         default:  state_d = S_FETCH;
      endcase
   end

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_RESET;
         retired <= '0;
      end else begin
         state_q <= state_d;
         if (ctrl.instr_done) retired <= retired + CNT_W'(1);
      end
   end

   assign state       = state_q;
   assign instr_done  = ctrl.instr_done;

   assign bus.pcwrite     = ctrl.pcwrite;
   assign bus.pcwritecond = ctrl.pcwritecond;
   assign bus.iord        = ctrl.iord;
   assign bus.memread     = ctrl.memread;
   assign bus.memwrite    = ctrl.memwrite;
   assign bus.irwrite     = ctrl.irwrite;
   assign bus.memtoreg    = ctrl.memtoreg;
   assign bus.regdst      = ctrl.regdst;
   assign bus.regwrite    = ctrl.regwrite;
   assign bus.alusrca     = ctrl.alusrca;
   assign bus.alusrcb     = ctrl.alusrcb;
   assign bus.aluop       = ctrl.aluop;
   assign bus.pcsource    = ctrl.pcsource;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle vector table on a 16-bit
// counter instance, plus counter wrap and reset-in-MEMWR on a 4-bit instance.
module tb_multicycle_control;
   import multicycle_pkg::*;

   // {pcwrite,pcwritecond,iord,memread,memwrite,irwrite,memtoreg,regdst,regwrite,alusrca,alusrcb,aluop,pcsource}
   localparam logic [15:0] E_ZERO   = 16'b0_0_0_0_0_0_0_0_0_0_00_00_00;
   localparam logic [15:0] E_FRDY   = 16'b1_0_0_1_0_1_0_0_0_0_01_00_00;
   localparam logic [15:0] E_FWAIT  = 16'b0_0_0_1_0_0_0_0_0_0_01_00_00;
   localparam logic [15:0] E_DEC    = 16'b0_0_0_0_0_0_0_0_0_0_11_00_00;
   localparam logic [15:0] E_MADR   = 16'b0_0_0_0_0_0_0_0_0_1_10_00_00;
   localparam logic [15:0] E_MRD    = 16'b0_0_1_1_0_0_0_0_0_0_00_00_00;
   localparam logic [15:0] E_MWB    = 16'b0_0_0_0_0_0_1_0_1_0_00_00_00;
   localparam logic [15:0] E_MWR    = 16'b0_0_1_0_1_0_0_0_0_0_00_00_00;
   localparam logic [15:0] E_REX    = 16'b0_0_0_0_0_0_0_0_0_1_00_10_00;
   localparam logic [15:0] E_RWB    = 16'b0_0_0_0_0_0_0_1_1_0_00_00_00;
   localparam logic [15:0] E_BEQ    = 16'b0_1_0_0_0_0_0_0_0_1_00_01_01;
   localparam logic [15:0] E_JMP    = 16'b1_0_0_0_0_0_0_0_0_0_00_00_10;

   typedef struct {
      logic        rst;
      logic [5:0]  op;
      logic        mr;
      logic [3:0]  st;
      logic [15:0] ctl;
      logic        done;
      logic        ill;
      logic [15:0] ret;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_a, reset_b;
   logic [3:0]  state_a, state_b;
   logic        done_a, done_b, ill_a, ill_b;
   logic [15:0] retired_a;
   logic [3:0]  retired_b;

   multicycle_control_if bus_a ();
   multicycle_control_if bus_b ();

   multicycle_control #(.CNT_W(16)) dut_a (
      .clk        (clk),
      .reset      (reset_a),
      .bus        (bus_a.master),
      .state      (state_a),
      .instr_done (done_a),
      .illegal_op (ill_a),
      .retired    (retired_a)
   );

   multicycle_control #(.CNT_W(4)) dut_b (
      .clk        (clk),
      .reset      (reset_b),
      .bus        (bus_b.master),
      .state      (state_b),
      .instr_done (done_b),
      .illegal_op (ill_b),
      .retired    (retired_b)
   );

   int total = 0;
   int bad   = 0;
   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic rst, input logic [5:0] op, input logic mr, input logic [3:0] st,
                      input logic [15:0] ctl, input logic done, input logic ill, input logic [15:0] ret);
      vec_t v;
      v.rst = rst; v.op = op; v.mr = mr; v.st = st;
      v.ctl = ctl; v.done = done; v.ill = ill; v.ret = ret;
      vecs.push_back(v);
   endtask

   function automatic logic [15:0] ctl_a();
      return {bus_a.pcwrite, bus_a.pcwritecond, bus_a.iord, bus_a.memread, bus_a.memwrite,
              bus_a.irwrite, bus_a.memtoreg, bus_a.regdst, bus_a.regwrite, bus_a.alusrca,
              bus_a.alusrcb, bus_a.aluop, bus_a.pcsource};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // reset held, then release; state stays RESET until the first edge after release
      add(1, OP_RTYPE, 1, 0,  E_ZERO, 0, 0, 0);
      add(1, OP_RTYPE, 1, 0,  E_ZERO, 0, 0, 0);
      add(1, OP_RTYPE, 1, 0,  E_ZERO, 0, 0, 0);
      add(0, OP_RTYPE, 1, 0,  E_ZERO, 0, 0, 0);
      // lw, no stalls: 1,2,3,4,5
      add(0, OP_LW,    1, 1,  E_FRDY, 0, 0, 0);
      add(0, OP_LW,    1, 2,  E_DEC,  0, 0, 0);
      add(0, OP_LW,    1, 3,  E_MADR, 0, 0, 0);
      add(0, OP_LW,    1, 4,  E_MRD,  0, 0, 0);
      add(0, OP_LW,    1, 5,  E_MWB,  1, 0, 0);
      // sw with two wait cycles in MEMWR
      add(0, OP_SW,    1, 1,  E_FRDY, 0, 0, 1);
      add(0, OP_SW,    1, 2,  E_DEC,  0, 0, 1);
      add(0, OP_SW,    1, 3,  E_MADR, 0, 0, 1);
      add(0, OP_SW,    0, 6,  E_MWR,  0, 0, 1);
      add(0, OP_SW,    0, 6,  E_MWR,  0, 0, 1);
      add(0, OP_SW,    1, 6,  E_MWR,  1, 0, 1);
      // R-type; mem_ready low where it must be ignored
      add(0, OP_RTYPE, 1, 1,  E_FRDY, 0, 0, 2);
      add(0, OP_RTYPE, 0, 2,  E_DEC,  0, 0, 2);
      add(0, OP_RTYPE, 0, 7,  E_REX,  0, 0, 2);
      add(0, OP_RTYPE, 1, 8,  E_RWB,  1, 0, 2);
      // beq
      add(0, OP_BEQ,   1, 1,  E_FRDY, 0, 0, 3);
      add(0, OP_BEQ,   1, 2,  E_DEC,  0, 0, 3);
      add(0, OP_BEQ,   1, 9,  E_BEQ,  1, 0, 3);
      // j
      add(0, OP_J,     1, 1,  E_FRDY, 0, 0, 4);
      add(0, OP_J,     1, 2,  E_DEC,  0, 0, 4);
      add(0, OP_J,     1, 10, E_JMP,  1, 0, 4);
      // illegal opcode
      add(0, 6'h3F,    1, 1,  E_FRDY, 0, 0, 5);
      add(0, 6'h3F,    1, 2,  E_DEC,  0, 1, 5);
      // fetch stall, then lw with a MEMRD stall and opcode changed after MEMADR
      add(0, OP_LW,    0, 1,  E_FWAIT,0, 0, 5);
      add(0, OP_LW,    1, 1,  E_FRDY, 0, 0, 5);
      add(0, OP_LW,    1, 2,  E_DEC,  0, 0, 5);
      add(0, OP_LW,    1, 3,  E_MADR, 0, 0, 5);
      add(0, 6'h3F,    0, 4,  E_MRD,  0, 0, 5);
      add(0, 6'h3F,    1, 4,  E_MRD,  0, 0, 5);
      add(0, 6'h3F,    1, 5,  E_MWB,  1, 0, 5);
      add(0, OP_J,     1, 1,  E_FRDY, 0, 0, 6);

      reset_a = 1'b1; bus_a.opcode = OP_RTYPE; bus_a.mem_ready = 1'b1;
      reset_b = 1'b1; bus_b.opcode = OP_J;     bus_b.mem_ready = 1'b1;
      tick();

      foreach (vecs[i]) begin
         reset_a         = vecs[i].rst;
         bus_a.opcode    = vecs[i].op;
         bus_a.mem_ready = vecs[i].mr;
         #1;
         check($sformatf("v%0d state", i),   32'(state_a),   32'(vecs[i].st));
         check($sformatf("v%0d ctrl", i),    32'(ctl_a()),   32'(vecs[i].ctl));
         check($sformatf("v%0d done", i),    32'(done_a),    32'(vecs[i].done));
         check($sformatf("v%0d illegal", i), 32'(ill_a),     32'(vecs[i].ill));
         check($sformatf("v%0d retired", i), 32'(retired_a), 32'(vecs[i].ret));
         tick();
      end

      // 4-bit counter: 17 jumps, wrap to 0 after the 16th
      reset_b = 1'b0;
      tick();
      for (int n = 0; n < 17; n++) begin
         check("wrap fetch state", 32'(state_b), 32'(S_FETCH));
         tick();
         check("wrap decode state", 32'(state_b), 32'(S_DECODE));
         tick();
         check("wrap jmp state", 32'(state_b), 32'(S_JMP));
         check("wrap jmp done", 32'(done_b), 32'd1);
         tick();
         check("wrap retired", 32'(retired_b), 32'((n + 1) % 16));
      end

      // sw stalled in MEMWR, then reset abandons it
      bus_b.opcode = OP_SW;
      tick();
      check("sw decode state", 32'(state_b), 32'(S_DECODE));
      tick();
      check("sw memadr state", 32'(state_b), 32'(S_MEMADR));
      bus_b.mem_ready = 1'b0;
      tick();
      check("sw memwr state", 32'(state_b), 32'(S_MEMWR));
      check("sw memwrite held", 32'(bus_b.memwrite), 32'd1);
      check("sw no retire while stalled", 32'(done_b), 32'd0);
      reset_b = 1'b1;
      tick();
      check("rst-in-memwr state", 32'(state_b), 32'(S_RESET));
      check("rst-in-memwr memwrite", 32'(bus_b.memwrite), 32'd0);
      check("rst-in-memwr retired", 32'(retired_b), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle sequencing FSM for the MIPS datapath (shared instruction/data memory, instruction register, single ALU reused for PC+4, branch target and address). It decodes the 6-bit opcode latched in the IR and steps the datapath through fetch, decode, execute, memory and write-back. It asserts one-hot-style control strobes each cycle and stalls on a memory ready handshake. It also counts retired instructions.

## Interface
- `CNT_W`, default 16, width of the retired-instruction counter.

- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `opcode` in 6: IR[31:26], valid from DECODE onward.
- `mem_ready` in 1: memory completes the current read/write this cycle.
- `pcwrite` out 1: unconditional PC load.
- `pcwritecond` out 1: PC load if ALU zero.
- `iord` out 1: memory address select, 0 = PC, 1 = ALUOut.
- `memread` out 1: memory read request.
- `memwrite` out 1: memory write request.
- `irwrite` out 1: IR load.
- `memtoreg` out 1: register write data, 0 = ALUOut, 1 = MDR.
- `regdst` out 1: destination register, 0 = rt, 1 = rd.
- `regwrite` out 1: register file write.
- `alusrca` out 1: ALU A input, 0 = PC, 1 = A.
- `alusrcb` out 2: ALU B input, 00 = B, 01 = 4, 10 = sext, 11 = sext<<2.
- `aluop` out 2: 00 = add, 01 = sub, 10 = funct.
- `pcsource` out 2: 00 = ALU, 01 = ALUOut, 10 = jump address.
- `state` out 4: current state encoding.
- `instr_done` out 1: one-cycle retire pulse.
- `illegal_op` out 1: one-cycle pulse on an undefined opcode.
- `retired` out CNT_W: retired-instruction count.

## Operation
- States and encodings: RESET=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, REX=7, RWB=8, BEQ=9, JMP=10. Encodings 11–15 are unreachable and go to FETCH.
- Outputs are Moore, decoded from `state`. The exceptions are `mem_ready` gating and the `illegal_op` pulse, which are also functions of inputs. Any signal not listed for a state is 0.
- RESET: all outputs 0. Next state is FETCH unconditionally.
- FETCH: `memread`=1, `alusrcb`=01.
  - `irwrite` and `pcwrite` are asserted only when `mem_ready`=1.
  - Stays in FETCH while `mem_ready`=0; otherwise goes to DECODE.
- DECODE: `alusrcb`=11. Next state by `opcode`:
  - 0x00 → REX
  - 0x23 → MEMADR
  - 0x2B → MEMADR
  - 0x04 → BEQ
  - 0x02 → JMP
  - any other opcode → `illegal_op`=1 for this cycle, next state FETCH, not counted as retired.
- MEMADR: `alusrca`=1, `alusrcb`=10. Next state MEMRD if `opcode`=0x23, else MEMWR.
- MEMRD: `memread`=1, `iord`=1. Waits on `mem_ready`, then goes to MEMWB.
- MEMWB: `regwrite`=1, `memtoreg`=1. Retires. Next state FETCH.
- MEMWR: `memwrite`=1, `iord`=1, held until `mem_ready`. Retires in the `mem_ready` cycle, then goes to FETCH.
- REX: `alusrca`=1, `aluop`=10. Next state RWB.
- RWB: `regdst`=1, `regwrite`=1. Retires. Next state FETCH.
- BEQ: `alusrca`=1, `aluop`=01, `pcwritecond`=1, `pcsource`=01. Retires. Next state FETCH.
- JMP: `pcwrite`=1, `pcsource`=10. Retires. Next state FETCH.
- Retire: `instr_done`=1 in each retiring cycle, and `retired` increments on that clock edge.
  - `retired` is modulo 2^CNT_W: all-ones wraps to 0.

## Timing
- `reset` sampled high: on the next edge the state becomes RESET and `retired` becomes 0. All outputs are 0 while in RESET.
  - This holds from any state, including mid-MEMWR. The pending write is abandoned, and the memory must treat a dropped `memwrite` as cancel.
- First FETCH occurs one cycle after `reset` deasserts.
- Cycles per instruction with `mem_ready`=1 throughout: lw 5, sw 4, R-type 4, beq 3, j 3, illegal 2.
  - Each `mem_ready`=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
- `memread`/`memwrite` stay asserted and stable for the whole wait. The transfer completes in the cycle `mem_ready`=1.
- `mem_ready` is ignored outside FETCH, MEMRD and MEMWR.
- `opcode` is sampled only in DECODE and MEMADR.

## Structure
- Package `multicycle_pkg` holds:
  - state encoding constants (4-bit);
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J;
  - `alusrcb`, `aluop` and `pcsource` encodings.
- Sub-module `mc_out_decode`: combinational state + `mem_ready` → control strobes.
- The top level holds the state register, next-state logic and retire counter.

## Test plan
- Reset held 3 cycles, then released with `mem_ready`=1 → `state` 0 with all outputs 0. The cycle after release, `state`=1 with `memread`=1, `irwrite`=1, `pcwrite`=1, `alusrcb`=01.
- `opcode` 0x23, `mem_ready`=1 → states 1,2,3,4,5,1. `instr_done` pulses only in state 5. `retired` goes 0→1. MEMWB shows `regwrite`=1, `memtoreg`=1.
- `opcode` 0x2B with `mem_ready` low for 2 cycles in MEMWR → `memwrite` held 3 cycles, `instr_done` in the third, then FETCH.
- R-type, beq and j back-to-back → cycle counts 4,3,3. BEQ shows `pcwritecond`=1, `pcsource`=01. JMP shows `pcwrite`=1, `pcsource`=10. `retired` reaches 3.
- `opcode` 0x3F → `illegal_op` pulses in DECODE, next state FETCH, `retired` unchanged.
- `CNT_W`=4, 16 retirements → `retired` wraps to 0. Then `reset` asserted in MEMWR → next state 0, `memwrite`=0, `retired`=0.
